// File: rtl/slave_port.sv
// Serial-bus slave endpoint. Deserialises a 16-bit address (MSB first), then
// either collects 8 write-data bits and strobes a single-cycle memory write,
// or requests a byte from the memory and shifts it back to the master MSB
// first. Every bus bit moves under a valid/ready handshake, and all bus-facing
// outputs are pure decodes of registered state.
module slave_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mode,
    input  logic                  wr_bus,
    input  logic                  master_valid,
    output logic                  slave_ready,
    output logic                  rd_bus,
    output logic                  slave_valid,
    input  logic                  master_ready,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wr_data,
    output logic                  s_wr_en,
    output logic                  s_rd_en,
    input  logic [DATA_WIDTH-1:0] s_rd_data,
    input  logic                  s_rd_valid
);

    localparam int CNT_W = $clog2(ADDR_WIDTH) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ADDR,
        WR_DATA,
        WRITE,
        RD_REQ,
        RD_DATA
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rdsr;

    // State register; an asynchronous reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ADDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake and strobe outputs, all driven from the current state.
    always_comb begin
        state_next  = state;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        s_wr_en     = 1'b0;
        s_rd_en     = 1'b0;
        case (state)
            ADDR: begin
                slave_ready = 1'b1;
                if (master_valid && (cnt == ADDR_LAST)) begin
                    state_next = mode ? WR_DATA : RD_REQ;
                end
            end
            WR_DATA: begin
                slave_ready = 1'b1;
                if (master_valid && (cnt == DATA_LAST)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                s_wr_en    = 1'b1;
                state_next = ADDR;
            end
            RD_REQ: begin
                s_rd_en = 1'b1;
                if (s_rd_valid) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                slave_valid = 1'b1;
                if (master_ready && (cnt == DATA_LAST)) begin
                    state_next = ADDR;
                end
            end
            default: begin
                state_next = ADDR;
            end
        endcase
    end

    // The read line is forced low whenever no read bit is being offered.
    assign rd_bus = slave_valid & rdsr[DATA_WIDTH-1];

    // Shift registers and bit counter; each advances only on an accepted bit, so gaps just hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            s_addr    <= '0;
            s_wr_data <= '0;
            rdsr      <= '0;
        end else begin
            case (state)
                ADDR: begin
                    if (master_valid) begin
                        s_addr <= {s_addr[ADDR_WIDTH-2:0], wr_bus};
                        cnt    <= (cnt == ADDR_LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end
                WR_DATA: begin
                    if (master_valid) begin
                        s_wr_data <= {s_wr_data[DATA_WIDTH-2:0], wr_bus};
                        cnt       <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    cnt <= '0;
                end
                RD_REQ: begin
                    if (s_rd_valid) begin
                        rdsr <= s_rd_data;
                    end
                end
                RD_DATA: begin
                    if (master_ready) begin
                        rdsr <= rdsr << 1;
                        cnt  <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: a bus-master driver, a behavioural slave memory with
// configurable read latency, and a passive monitor feeding scenario tasks.
module tb_slave_port;

    logic        clk;
    logic        rstn;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        master_ready;
    logic        slave_ready;
    logic        rd_bus;
    logic        slave_valid;
    logic [15:0] s_addr;
    logic [7:0]  s_wr_data;
    logic        s_wr_en;
    logic        s_rd_en;
    logic [7:0]  s_rd_data = 8'h00;
    logic        s_rd_valid = 1'b0;

    int checks = 0;
    int passed = 0;

    slave_port #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mode        (mode),
        .wr_bus      (wr_bus),
        .master_valid(master_valid),
        .slave_ready (slave_ready),
        .rd_bus      (rd_bus),
        .slave_valid (slave_valid),
        .master_ready(master_ready),
        .s_addr      (s_addr),
        .s_wr_data   (s_wr_data),
        .s_wr_en     (s_wr_en),
        .s_rd_en     (s_rd_en),
        .s_rd_data   (s_rd_data),
        .s_rd_valid  (s_rd_valid)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave memory: absorbs write strobes and answers reads after mem_latency cycles.
    int         mem_latency = 0;
    bit         tie_valid = 1'b0;
    int         req_age = 0;
    logic [7:0] mem [logic [15:0]];
    logic [7:0] preload [logic [15:0]];

    function automatic logic [7:0] mem_lookup(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        if (preload.exists(a)) return preload[a];
        return 8'h00;
    endfunction

    always begin
        @(negedge clk);
        if (rstn && s_wr_en) mem[s_addr] = s_wr_data;
        if (rstn && s_rd_en) begin
            if (tie_valid || req_age >= mem_latency) begin
                s_rd_valid = 1'b1;
                s_rd_data  = mem_lookup(s_addr);
            end else begin
                s_rd_valid = 1'b0;
                s_rd_data  = 8'($urandom);
            end
            req_age++;
        end else begin
            req_age    = 0;
            s_rd_valid = tie_valid || ($urandom_range(3) == 0);
            s_rd_data  = 8'($urandom);
        end
    end

    // Passive monitor: cycle numbering, accepts, strobes and handshake-edge timestamps.
    int          cyc = 0;
    int          acc_q[$];
    int          wr_strobes = 0;
    int          wr_cyc_last = 0;
    logic [15:0] wr_addr_last = '0;
    logic [7:0]  wr_data_last = '0;
    int          ready_low = 0;
    int          rd_en_cycles = 0;
    int          rd_rises = 0;
    int          rd_rise_cyc = 0;
    int          sv_rise_cyc = 0;
    int          rdbus_bad = 0;
    logic        prev_rd_en = 1'b0;
    logic        prev_sv = 1'b0;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rstn) begin
            if (master_valid && slave_ready) acc_q.push_back(cyc);
            if (s_wr_en) begin
                wr_strobes++;
                wr_cyc_last  = cyc;
                wr_addr_last = s_addr;
                wr_data_last = s_wr_data;
            end
            if (!slave_ready) ready_low++;
            if (s_rd_en) rd_en_cycles++;
            if (s_rd_en && !prev_rd_en) begin
                rd_rises++;
                rd_rise_cyc = cyc;
            end
            if (slave_valid && !prev_sv) sv_rise_cyc = cyc;
            if (!slave_valid && rd_bus) rdbus_bad++;
        end
        prev_rd_en = s_rd_en;
        prev_sv    = slave_valid;
    end

    // Hard stop in case something upstream wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_bits(input logic [23:0] bits, input int n, input int gap_pct,
                             output bit ok, output bit first_ready);
        int idx   = n - 1;
        int guard = 0;
        bit first = 1'b1;
        first_ready = 1'b0;
        while (idx >= 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
            master_ready = 1'b0;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                master_valid = 1'b0;
                wr_bus       = 1'($urandom);
            end else begin
                master_valid = 1'b1;
                wr_bus       = bits[idx];
                if (first) begin
                    first_ready = slave_ready;
                    first       = 1'b0;
                end
                if (slave_ready) idx--;
            end
        end
        ok = (idx < 0);
    endtask

    task automatic recv_bits(input int gap_pct, output logic [7:0] data, output bit ok);
        int got   = 0;
        int guard = 0;
        data = '0;
        while (got < 8 && guard < 2000) begin
            @(negedge clk);
            guard++;
            master_valid = !slave_ready && ($urandom_range(1) == 1);
            wr_bus       = 1'($urandom);
            master_ready = !(gap_pct > 0 && $urandom_range(99) < gap_pct);
            if (slave_valid && master_ready) begin
                data = {data[6:0], rd_bus};
                got++;
            end
        end
        ok = (got == 8);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap,
                            output bit ok, output bit first_ready);
        mode = 1'b1;
        send_bits({a, d}, 24, gap, ok, first_ready);
        @(negedge clk);
        master_valid = 1'b0;
        wr_bus       = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input int gap, output logic [7:0] d,
                           output bit ok, output bit first_ready);
        bit ok1;
        bit ok2;
        mode = 1'b0;
        send_bits({8'h00, a}, 16, gap, ok1, first_ready);
        recv_bits(gap, d, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            master_valid = 1'b0;
            master_ready = 1'b0;
            wr_bus       = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn         = 1'b1;
        mode         = 1'b0;
        wr_bus       = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({slave_ready, slave_valid, rd_bus, s_wr_en, s_rd_en} !== 5'b10000)
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {slave_ready, slave_valid, rd_bus, s_wr_en, s_rd_en}, 5'b10000);
        else passed++;
        checks++;
        if ({s_addr, s_wr_data} !== 24'h0)
            $display("[TB] FAIL reset_regs: got %h expected %h", {s_addr, s_wr_data}, 24'h0);
        else passed++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_write_basic();
        int n0 = acc_q.size();
        int w0 = wr_strobes;
        int r0 = ready_low;
        bit ok;
        bit fr;
        do_write(16'h1234, 8'hA5, 0, ok, fr);
        idle(2);
        checks++;
        if (!ok || acc_q.size() - n0 != 24)
            $display("[TB] FAIL wr_accepts: got %0d expected %0d", acc_q.size() - n0, 24);
        else passed++;
        checks++;
        if (wr_strobes - w0 != 1)
            $display("[TB] FAIL wr_strobe_count: got %0d expected %0d", wr_strobes - w0, 1);
        else passed++;
        checks++;
        if ({wr_addr_last, wr_data_last} !== {16'h1234, 8'hA5})
            $display("[TB] FAIL wr_addr_data: got %h expected %h",
                     {wr_addr_last, wr_data_last}, {16'h1234, 8'hA5});
        else passed++;
        checks++;
        if (acc_q.size() > n0 && wr_cyc_last - acc_q[n0] + 1 != 25)
            $display("[TB] FAIL wr_strobe_cycle: got %0d expected %0d", wr_cyc_last - acc_q[n0] + 1, 25);
        else passed++;
        checks++;
        if (ready_low - r0 != 1)
            $display("[TB] FAIL wr_ready_low: got %0d expected %0d", ready_low - r0, 1);
        else passed++;
    endtask

    task automatic test_read_latency();
        int          e0 = rd_en_cycles;
        int          q0 = rd_rises;
        logic [7:0]  d;
        bit          ok;
        bit          fr;
        preload[16'h8001] = 8'h3C;
        mem_latency       = 3;
        do_read(16'h8001, 0, d, ok, fr);
        idle(2);
        checks++;
        if (!ok || d !== 8'h3C)
            $display("[TB] FAIL rd_data: got %h expected %h (ok=%0d)", d, 8'h3C, ok);
        else passed++;
        checks++;
        if (rd_en_cycles - e0 != 4 || rd_rises - q0 != 1)
            $display("[TB] FAIL rd_en_len: got %0d cycles/%0d pulses expected 4/1",
                     rd_en_cycles - e0, rd_rises - q0);
        else passed++;
        checks++;
        if (rd_rise_cyc - acc_q[$] != 1)
            $display("[TB] FAIL rd_en_start: got %0d expected %0d", rd_rise_cyc - acc_q[$], 1);
        else passed++;
        checks++;
        if (sv_rise_cyc - rd_rise_cyc != 4)
            $display("[TB] FAIL rd_latency: got %0d expected %0d", sv_rise_cyc - rd_rise_cyc, 4);
        else passed++;
        checks++;
        if (slave_ready !== 1'b1)
            $display("[TB] FAIL rd_ready_after: got %b expected %b", slave_ready, 1'b1);
        else passed++;
    endtask

    task automatic test_zero_latency();
        logic [15:0] a = 16'h6000 | 16'($urandom_range(255));
        int          e0 = rd_en_cycles;
        logic [7:0]  d;
        bit          ok;
        bit          fr;
        preload[a] = 8'hFF;
        tie_valid  = 1'b1;
        do_read(a, 0, d, ok, fr);
        idle(2);
        tie_valid = 1'b0;
        checks++;
        if (!ok || d !== 8'hFF)
            $display("[TB] FAIL zl_data: got %h expected %h (ok=%0d)", d, 8'hFF, ok);
        else passed++;
        checks++;
        if (rd_en_cycles - e0 != 1 || sv_rise_cyc - rd_rise_cyc != 1)
            $display("[TB] FAIL zl_rd_req: got %0d req cycles, valid after %0d expected 1/1",
                     rd_en_cycles - e0, sv_rise_cyc - rd_rise_cyc);
        else passed++;
        checks++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0)
            $display("[TB] FAIL zl_back_to_addr: got ready=%b valid=%b expected 1/0", slave_ready, slave_valid);
        else passed++;
    endtask

    task automatic test_gaps();
        int         w0 = wr_strobes;
        int         q0;
        logic [7:0] d;
        bit         ok;
        bit         fr;
        do_write(16'hFFFF, 8'h5A, 40, ok, fr);
        idle(1);
        checks++;
        if (!ok || wr_strobes - w0 != 1 || {wr_addr_last, wr_data_last} !== {16'hFFFF, 8'h5A})
            $display("[TB] FAIL gap_write: got %h x%0d expected %h x1",
                     {wr_addr_last, wr_data_last}, wr_strobes - w0, {16'hFFFF, 8'h5A});
        else passed++;
        q0 = rd_rises;
        preload[16'h2468] = 8'h81;
        mem_latency       = $urandom_range(5);
        do_read(16'h2468, 40, d, ok, fr);
        idle(2);
        checks++;
        if (!ok || d !== 8'h81 || rd_rises - q0 != 1)
            $display("[TB] FAIL gap_read: got %h x%0d expected %h x1", d, rd_rises - q0, 8'h81);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int w0 = wr_strobes;
        bit ok;
        bit fr;
        mode = 1'b1;
        send_bits(24'h0003FF, 10, 0, ok, fr);
        @(posedge clk);
        #2;
        rstn         = 1'b0;
        master_valid = 1'b0;
        #1;
        checks++;
        if ({slave_ready, slave_valid, rd_bus, s_wr_en, s_rd_en} !== 5'b10000)
            $display("[TB] FAIL midrst_outputs: got %b expected %b",
                     {slave_ready, slave_valid, rd_bus, s_wr_en, s_rd_en}, 5'b10000);
        else passed++;
        checks++;
        if ({s_addr, s_wr_data} !== 24'h0)
            $display("[TB] FAIL midrst_regs: got %h expected %h", {s_addr, s_wr_data}, 24'h0);
        else passed++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(2);
        checks++;
        if (wr_strobes != w0)
            $display("[TB] FAIL midrst_no_strobe: got %0d expected %0d", wr_strobes, w0);
        else passed++;
        do_write(16'h0002, 8'h01, 0, ok, fr);
        idle(1);
        checks++;
        if (!ok || wr_strobes - w0 != 1 || {wr_addr_last, wr_data_last} !== {16'h0002, 8'h01})
            $display("[TB] FAIL midrst_write: got %h x%0d expected %h x1",
                     {wr_addr_last, wr_data_last}, wr_strobes - w0, {16'h0002, 8'h01});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bit         ok1;
        bit         ok2;
        bit         fr1;
        bit         fr2;
        mem_latency = 2;
        do_write(16'h4242, 8'hC3, 0, ok1, fr1);
        do_read(16'h4242, 0, d, ok2, fr2);
        idle(2);
        checks++;
        if (!ok1 || !ok2 || d !== 8'hC3)
            $display("[TB] FAIL b2b_data: got %h expected %h", d, 8'hC3);
        else passed++;
        checks++;
        if (fr2 !== 1'b1)
            $display("[TB] FAIL b2b_fetch_ready: got %b expected %b", fr2, 1'b1);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0]  exp_mem [logic [15:0]];
        logic [15:0] wq[$];
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  got;
        logic [7:0]  exp_d;
        int          gap;
        int          w0;
        bit          ok;
        bit          fr;
        for (int i = 0; i < 10; i++) begin
            gap         = $urandom_range(50);
            mem_latency = $urandom_range(4);
            if (wq.size() == 0 || $urandom_range(1) == 1) begin
                a  = 16'($urandom_range(16'hBFFF));
                d  = 8'($urandom);
                w0 = wr_strobes;
                exp_mem[a] = d;
                wq.push_back(a);
                do_write(a, d, gap, ok, fr);
                idle(1);
                checks++;
                if (!ok || wr_strobes - w0 != 1 || {wr_addr_last, wr_data_last} !== {a, d})
                    $display("[TB] FAIL rand_write[%0d]: got %h x%0d expected %h x1",
                             i, {wr_addr_last, wr_data_last}, wr_strobes - w0, {a, d});
                else passed++;
            end else begin
                if ($urandom_range(1) == 1) begin
                    a     = wq[$urandom_range(wq.size() - 1)];
                    exp_d = exp_mem[a];
                end else begin
                    a          = 16'hC000 | 16'($urandom_range(16'h0FFF));
                    exp_d      = 8'($urandom);
                    preload[a] = exp_d;
                end
                do_read(a, gap, got, ok, fr);
                idle(1);
                checks++;
                if (!ok || got !== exp_d)
                    $display("[TB] FAIL rand_read[%0d]: addr %h got %h expected %h", i, a, got, exp_d);
                else passed++;
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        idle(2);
        test_write_basic();
        test_read_latency();
        test_zero_latency();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        idle(2);
        checks++;
        if (rdbus_bad != 0)
            $display("[TB] FAIL rd_bus_idle_low: got %0d violations expected %0d", rdbus_bad, 0);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/slave_port.md
# slave_port

Serial-bus slave endpoint: the downstream counterpart of the bus master port. It deserialises a 16-bit address (MSB first) from the shared bus. It then either deserialises 8 write-data bits and issues a single-cycle write to the attached slave memory, or fetches a byte from the memory and serialises it back to the master MSB first. Every bit on the bus moves under a valid/ready handshake.

## Interface
- ADDR_WIDTH, 16, address bits received per transaction
- DATA_WIDTH, 8, data bits per transaction
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- mode  in  1  bus transaction type: 1 = write, 0 = read; held by the master for the whole transaction
- wr_bus  in  1  serial address/write-data bit from the master
- master_valid  in  1  wr_bus carries a valid bit
- slave_ready  out  1  slave accepts wr_bus this cycle
- rd_bus  out  1  serial read-data bit to the master
- slave_valid  out  1  rd_bus carries a valid bit
- master_ready  in  1  master accepts rd_bus this cycle
- s_addr  out  ADDR_WIDTH  captured address to the memory
- s_wr_data  out  DATA_WIDTH  captured write data to the memory
- s_wr_en  out  1  single-cycle memory write strobe
- s_rd_en  out  1  memory read request; held until s_rd_valid
- s_rd_data  in  DATA_WIDTH  memory read data; valid when s_rd_valid=1
- s_rd_valid  in  1  memory read data valid

## Operation
- States: ADDR (idle/reset state), WR_DATA, WRITE, RD_REQ, RD_DATA; bit counter cnt, width clog2(ADDR_WIDTH)+1.
- Bit accept: a bus bit transfers in a cycle with master_valid & slave_ready. Master to slave bits are sampled from wr_bus. A bit transfers to the master in a cycle with slave_valid & master_ready.
- ADDR:
  - slave_ready=1.
  - On accept: s_addr <= {s_addr[ADDR_WIDTH-2:0], wr_bus}; cnt++.
  - On the accept with cnt==ADDR_WIDTH-1: cnt<=0; mode is sampled; go to WR_DATA if mode=1, else RD_REQ.
- WR_DATA:
  - slave_ready=1.
  - On accept: s_wr_data shifts left with wr_bus as LSB; cnt++.
  - On the accept with cnt==DATA_WIDTH-1: go to WRITE.
- WRITE:
  - slave_ready=0; s_wr_en=1 for exactly one cycle; s_addr and s_wr_data hold stable.
  - Next: cnt<=0, go to ADDR.
- RD_REQ:
  - slave_ready=0; s_rd_en=1.
  - On s_rd_valid: the shift register rdsr <= s_rd_data; go to RD_DATA. s_rd_valid may arrive in the first RD_REQ cycle (zero-latency memory).
- RD_DATA:
  - slave_ready=0; slave_valid=1; rd_bus=rdsr[DATA_WIDTH-1].
  - On accept: rdsr <= rdsr<<1; cnt++.
  - On the accept with cnt==DATA_WIDTH-1: cnt<=0; go to ADDR.
- Gaps: master_valid low in ADDR or WR_DATA, or master_ready low in RD_DATA, stalls with all registers held. There is no timeout.
- Other inputs: wr_bus and master_valid are ignored outside ADDR and WR_DATA. s_rd_valid is ignored outside RD_REQ.
- rd_bus=0 whenever slave_valid=0.
- s_addr and s_wr_data keep their last values between transactions. A new transaction overwrites them bit by bit.

## Timing
- Reset (asynchronous, any state): state=ADDR, cnt=0, s_addr=0, s_wr_data=0, rdsr=0.
- Output values in reset: slave_ready=1, slave_valid=0, rd_bus=0, s_wr_en=0, s_rd_en=0.
- Reset mid-transaction: the transaction is discarded; no write or read strobe is issued.
- Write, back-to-back handshakes: 16 address cycles + 8 data cycles. s_wr_en is high in the cycle after the 8th data accept. slave_ready is high again the following cycle. Total 26 cycles from the first accept to ready again.
- Read: s_rd_en rises the cycle after the 16th address accept.
  - With memory latency L (L=0 means s_rd_valid in the same cycle), slave_valid rises L+1 cycles after s_rd_en rises.
  - 8 read bits follow. slave_ready returns high the cycle after the 8th accept.
- slave_ready is low for exactly 1 cycle after a write. Because of that, the master's FETCH check (which samples slave_ready) always sees ready=1 once the slave has returned to ADDR.
- All outputs are registered-state decodes; no combinational path from bus inputs to bus outputs.

## Test plan
- Write 0xA5 to 0x1234, master_valid continuous:
  - s_wr_en pulses once, with s_addr=0x1234 and s_wr_data=0xA5, at cycle 25 after the first accept.
  - slave_ready is low for exactly 1 cycle.
- Read 0x8001, memory returns 0x3C after 3 cycles:
  - s_rd_en is held for 4 cycles.
  - rd_bus sequence is 0,0,1,1,1,1,0,0 with slave_valid=1.
  - The master captures 0x3C.
- Zero-latency read (s_rd_valid tied high), data 0xFF:
  - RD_REQ lasts 1 cycle; 8 bits of 1 are sent.
  - The slave is back in ADDR with slave_ready=1.
- Random master_valid gaps during a write of 0x5A to 0xFFFF, and random master_ready gaps during a read of 0x81:
  - Captured and returned values are unchanged.
  - Exactly one strobe per transaction.
- Assert rstn after 10 address bits:
  - All outputs are at reset values immediately.
  - A following full write of 0x01 to 0x0002 completes correctly, with no stale address bits.
- Back-to-back write then read of the same address 0x4242, with the memory model echoing the written byte 0xC3:
  - The read returns 0xC3.
  - The master's FETCH check never sees slave_ready=0.
